sc_regbank_rw: RTL

Writable register bank, the read/write counterpart to the team's fixed-value register. Holds NREGS words.
- Single write port: address/data/valid, with a registered write stage that commits one cycle later.
- Two combinational read ports feed the datapath buses.
- Register 0 is hardwired to a constant, so it behaves like a fixed register inside the bank.

---
 rtl/sc_regbank_pkg.sv | 25 ++
 rtl/sc_regbank_rw_if.sv | 48 ++++
 rtl/sc_regbank_readport.sv | 45 ++++
 rtl/sc_regbank_rw.sv | 99 +++++++++
 4 files changed

// File: rtl/sc_regbank_pkg.sv
// -----------------------------------------------------------------------------
// sc_regbank_pkg
// Shared definitions for the read/write register bank (sc_regbank_rw):
//   - default word/address widths and the hardwired register-0 value
//   - word_t / addr_t types used by the bank and its read ports
//   - pend_t : contents of the registered write stage
// Optional feature macro used by the bank: SC_REGBANK_BYPASS_EN
// -----------------------------------------------------------------------------
package sc_regbank_pkg;

    localparam int          DATAWIDTH_BUS_DEF   = 32;
    localparam int          ADDRWIDTH_DEF       = 3;
    localparam logic [31:0] DATA_REG0_CONST_DEF = 32'h0000_0000;

    typedef logic [DATAWIDTH_BUS_DEF-1:0] word_t;
    typedef logic [ADDRWIDTH_DEF-1:0]     addr_t;

    // Write accepted on the previous edge, waiting to land in the array.
    typedef struct packed {
        logic  valid;
        addr_t addr;
        word_t data;
    } pend_t;

endpackage

// File: rtl/sc_regbank_rw_if.sv
// -----------------------------------------------------------------------------
// sc_regbank_rw_if
// Bus bundle of the register bank: one write port (valid/addr/data), two
// combinational read ports, the write-error pulse and the busy flag.
//   master : drives write request and read addresses (datapath side)
//   slave  : the register bank
// Optional feature macro of the bank: SC_REGBANK_BYPASS_EN (no effect here).
// -----------------------------------------------------------------------------
interface sc_regbank_rw_if
    import sc_regbank_pkg::*;
#(
    parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
    parameter int ADDRWIDTH     = ADDRWIDTH_DEF
);
    logic                     SC_RegBANK_wr_valid_InHigh;
    logic [ADDRWIDTH-1:0]     SC_RegBANK_wr_addr_InBUS;
    logic [DATAWIDTH_BUS-1:0] SC_RegBANK_wr_data_InBUS;
    logic [ADDRWIDTH-1:0]     SC_RegBANK_rdA_addr_InBUS;
    logic [ADDRWIDTH-1:0]     SC_RegBANK_rdB_addr_InBUS;
    logic [DATAWIDTH_BUS-1:0] SC_RegBANK_rdA_data_OutBUS;
    logic [DATAWIDTH_BUS-1:0] SC_RegBANK_rdB_data_OutBUS;
    logic                     SC_RegBANK_wr_err_OutHigh;
    logic                     SC_RegBANK_busy_OutHigh;

    modport master (
        output SC_RegBANK_wr_valid_InHigh,
        output SC_RegBANK_wr_addr_InBUS,
        output SC_RegBANK_wr_data_InBUS,
        output SC_RegBANK_rdA_addr_InBUS,
        output SC_RegBANK_rdB_addr_InBUS,
        input  SC_RegBANK_rdA_data_OutBUS,
        input  SC_RegBANK_rdB_data_OutBUS,
        input  SC_RegBANK_wr_err_OutHigh,
        input  SC_RegBANK_busy_OutHigh
    );

    modport slave (
        input  SC_RegBANK_wr_valid_InHigh,
        input  SC_RegBANK_wr_addr_InBUS,
        input  SC_RegBANK_wr_data_InBUS,
        input  SC_RegBANK_rdA_addr_InBUS,
        input  SC_RegBANK_rdB_addr_InBUS,
        output SC_RegBANK_rdA_data_OutBUS,
        output SC_RegBANK_rdB_data_OutBUS,
        output SC_RegBANK_wr_err_OutHigh,
        output SC_RegBANK_busy_OutHigh
    );
endinterface

// File: rtl/sc_regbank_readport.sv
// -----------------------------------------------------------------------------
// sc_regbank_readport
// One combinational read port of the register bank.
//   i_addr       : read address
//   i_array_data : array word already selected by i_addr (don't-care for 0)
//   i_pend       : registered write stage of the bank
//   o_data       : DATA_REG0_CONST for address 0, otherwise the array word
//                  (or the pending word when forwarding is enabled)
// Macro SC_REGBANK_BYPASS_EN: when defined, a read hitting the pending write
// returns the pending data one edge before it commits.
// -----------------------------------------------------------------------------
module sc_regbank_readport
    import sc_regbank_pkg::*;
#(
    parameter word_t DATA_REG0_CONST = DATA_REG0_CONST_DEF
)(
    input  addr_t i_addr,
    input  word_t i_array_data,
    input  pend_t i_pend,
    output word_t o_data
);

`ifdef SC_REGBANK_BYPASS_EN
    logic w_hit;
    // Pending address is never 0, the explicit check keeps register 0 fixed
    // even if that ever changes.
    assign w_hit = i_pend.valid && (i_pend.addr == i_addr) && (i_addr != '0);
`else
    logic w_unused_pend;
    assign w_unused_pend = ^i_pend;
`endif

    always_comb begin
        o_data = i_array_data;
        if (i_addr == '0) begin
            o_data = DATA_REG0_CONST;
        end
`ifdef SC_REGBANK_BYPASS_EN
        else if (w_hit) begin
            o_data = i_pend.data;
        end
`endif
    end

endmodule

// File: rtl/sc_regbank_rw.sv
// -----------------------------------------------------------------------------
// sc_regbank_rw
// Writable register bank of 2**ADDRWIDTH words; register 0 is hardwired to
// DATA_REG0_CONST and has no storage.
// Ports:
//   SC_RegFIXED_CLOCK_50     : clock
//   SC_RegFIXED_RESET_InHigh : asynchronous active-high reset
//   bus (sc_regbank_rw_if.slave):
//     wr_valid/wr_addr/wr_data : write request, registered then committed
//                                on the following edge
//     rdA/rdB addr/data        : two independent combinational read ports
//     wr_err                   : one-cycle pulse, write to address 0 dropped
//     busy                     : a write is waiting in the stage register
// Macro SC_REGBANK_BYPASS_EN: forward the pending write to the read ports.
// -----------------------------------------------------------------------------
module sc_regbank_rw
    import sc_regbank_pkg::*;
#(
    parameter int    DATAWIDTH_BUS     = DATAWIDTH_BUS_DEF,
    parameter int    ADDRWIDTH         = ADDRWIDTH_DEF,
    parameter word_t DATA_REG0_CONST   = DATA_REG0_CONST_DEF,
    parameter word_t DATA_REGBANK_INIT = '0
)(
    input  logic            SC_RegFIXED_CLOCK_50,
    input  logic            SC_RegFIXED_RESET_InHigh,
    sc_regbank_rw_if.slave  bus
);

    localparam int NREGS = 2**ADDRWIDTH;

    // Slot 0 deliberately absent: it is a constant, not storage.
    logic [DATAWIDTH_BUS-1:0] r_array [1:NREGS-1];
    pend_t                    r_pend;
    logic                     r_wr_err;

    logic [DATAWIDTH_BUS-1:0] w_rdA_arr;
    logic [DATAWIDTH_BUS-1:0] w_rdB_arr;
    logic                     w_wr_accept;

    assign w_wr_accept = bus.SC_RegBANK_wr_valid_InHigh &&
                         (bus.SC_RegBANK_wr_addr_InBUS != '0);

    always_ff @(posedge SC_RegFIXED_CLOCK_50 or posedge SC_RegFIXED_RESET_InHigh) begin
        if (SC_RegFIXED_RESET_InHigh) begin
            for (int i = 1; i < NREGS; i++) begin
                r_array[i] <= DATA_REGBANK_INIT;
            end
            r_pend   <= '0;
            r_wr_err <= 1'b0;
        end else begin
            // Commit stage: the word captured on the previous edge lands now.
            if (r_pend.valid) begin
                r_array[r_pend.addr] <= r_pend.data;
            end
            // Capture stage: addr/data only move on an accepted write.
            r_pend.valid <= w_wr_accept;
            if (w_wr_accept) begin
                r_pend.addr <= bus.SC_RegBANK_wr_addr_InBUS;
                r_pend.data <= bus.SC_RegBANK_wr_data_InBUS;
            end
            r_wr_err <= bus.SC_RegBANK_wr_valid_InHigh &&
                        (bus.SC_RegBANK_wr_addr_InBUS == '0);
        end
    end

    // Address 0 would index outside the array; the read port discards it.
    always_comb begin
        w_rdA_arr = '0;
        w_rdB_arr = '0;
        if (bus.SC_RegBANK_rdA_addr_InBUS != '0) begin
            w_rdA_arr = r_array[bus.SC_RegBANK_rdA_addr_InBUS];
        end
        if (bus.SC_RegBANK_rdB_addr_InBUS != '0) begin
            w_rdB_arr = r_array[bus.SC_RegBANK_rdB_addr_InBUS];
        end
    end

    sc_regbank_readport #(
        .DATA_REG0_CONST (DATA_REG0_CONST)
    ) u_rdA (
        .i_addr       (bus.SC_RegBANK_rdA_addr_InBUS),
        .i_array_data (w_rdA_arr),
        .i_pend       (r_pend),
        .o_data       (bus.SC_RegBANK_rdA_data_OutBUS)
    );

    sc_regbank_readport #(
        .DATA_REG0_CONST (DATA_REG0_CONST)
    ) u_rdB (
        .i_addr       (bus.SC_RegBANK_rdB_addr_InBUS),
        .i_array_data (w_rdB_arr),
        .i_pend       (r_pend),
        .o_data       (bus.SC_RegBANK_rdB_data_OutBUS)
    );

    assign bus.SC_RegBANK_wr_err_OutHigh = r_wr_err;
    assign bus.SC_RegBANK_busy_OutHigh   = r_pend.valid;

endmodule
